// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge port between the MEM stage controller and memory.
// The controller holds mem_req and the request fields steady until mem_ack (a single-cycle pulse) or a timeout.
interface mem_stage_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: runs loads and stores on a req/ack memory port and stalls upstream while an access is outstanding.
// It presents a registered writeback bundle to the MEM/WB stage.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt_sys,
    input  logic [1:0]             in_memc,
    input  logic                   in_reg_wr,
    input  logic [31:0]            in_alu,
    input  logic [15:0]            in_R1_data,
    input  logic                   in_R0_en,
    input  logic [7:0]             in_instr,
    output logic                   stall,
    mem_stage_ctrl_if.master       mem,
    output logic                   mem_err,
    output logic                   wb_valid,
    output logic                   wb_reg_wr,
    output logic [15:0]            wb_data,
    output logic [15:0]            wb_R0_data,
    output logic                   wb_R0_en,
    output logic [7:0]             wb_instr,
    output logic [1:0]             o_dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_abort;
    logic        r_err;
    logic        r_wb_valid;
    logic        r_wb_reg_wr;
    logic [15:0] r_wb_data;
    logic [15:0] r_wb_R0_data;
    logic        r_wb_R0_en;
    logic [7:0]  r_wb_instr;

    logic        w_mem_op;
    logic        w_stall;

    assign w_mem_op = (in_memc == 2'b01) || (in_memc == 2'b10);

    // Stall is held low while in reset so upstream is never frozen by a dropped access.
    assign w_stall = rst && (halt_sys || (r_state == WAIT) ||
                             ((r_state == IDLE) && w_mem_op));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_abort      <= 1'b0;
            r_err        <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_reg_wr  <= 1'b0;
            r_wb_data    <= '0;
            r_wb_R0_data <= '0;
            r_wb_R0_en   <= 1'b0;
            r_wb_instr   <= '0;
        end else if (!halt_sys) begin
            r_wb_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        r_req   <= 1'b1;
                        r_we    <= (in_memc == 2'b10);
                        r_addr  <= in_alu[15:0];
                        r_wdata <= in_R1_data;
                        r_rdata <= '0;
                        r_cnt   <= '0;
                        r_abort <= 1'b0;
                        r_state <= WAIT;
                    end else begin
                        r_wb_valid   <= 1'b1;
                        r_wb_reg_wr  <= in_reg_wr;
                        r_wb_data    <= in_alu[15:0];
                        r_wb_R0_data <= in_alu[31:16];
                        r_wb_R0_en   <= in_R0_en;
                        r_wb_instr   <= in_instr;
                    end
                end
                WAIT: begin
                    // An ack on the final counted cycle still completes the access.
                    if (mem.mem_ack) begin
                        r_rdata <= mem.mem_rdata;
                        r_req   <= 1'b0;
                        r_state <= RESP;
                    end else if (r_cnt == LP_LAST) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_abort <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    // Upstream is still holding the memory op here, so in_* describe it.
                    r_wb_valid   <= 1'b1;
                    r_wb_reg_wr  <= in_reg_wr && !r_we && !r_abort;
                    r_wb_data    <= r_we ? in_alu[15:0] : r_rdata;
                    r_wb_R0_data <= in_alu[31:16];
                    r_wb_R0_en   <= in_R0_en && !r_abort;
                    r_wb_instr   <= in_instr;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stall         = w_stall;
    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign mem_err       = r_err;
    assign wb_valid      = r_wb_valid;
    assign wb_reg_wr     = r_wb_reg_wr;
    assign wb_data       = r_wb_data;
    assign wb_R0_data    = r_wb_R0_data;
    assign wb_R0_en      = r_wb_R0_en;
    assign wb_instr      = r_wb_instr;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (TIMEOUT=4): non-mem op, load, store, halt, timeout and mid-access reset.
// Inputs change 1 time unit after the rising edge; outputs are checked there, or 1 unit later for combinational stall.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        halt_sys;
  logic [1:0]  in_memc;
  logic        in_reg_wr;
  logic [31:0] in_alu;
  logic [15:0] in_R1_data;
  logic        in_R0_en;
  logic [7:0]  in_instr;
  logic        stall;
  logic        mem_err;
  logic        wb_valid;
  logic        wb_reg_wr;
  logic [15:0] wb_data;
  logic [15:0] wb_R0_data;
  logic        wb_R0_en;
  logic [7:0]  wb_instr;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl_if mif ();

  mem_stage_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .halt_sys   (halt_sys),
    .in_memc    (in_memc),
    .in_reg_wr  (in_reg_wr),
    .in_alu     (in_alu),
    .in_R1_data (in_R1_data),
    .in_R0_en   (in_R0_en),
    .in_instr   (in_instr),
    .stall      (stall),
    .mem        (mif.master),
    .mem_err    (mem_err),
    .wb_valid   (wb_valid),
    .wb_reg_wr  (wb_reg_wr),
    .wb_data    (wb_data),
    .wb_R0_data (wb_R0_data),
    .wb_R0_en   (wb_R0_en),
    .wb_instr   (wb_instr),
    .o_dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] memc, input logic reg_wr, input logic [31:0] alu,
                        input logic [15:0] r1, input logic r0_en, input logic [7:0] instr);
    in_memc    = memc;
    in_reg_wr  = reg_wr;
    in_alu     = alu;
    in_R1_data = r1;
    in_R0_en   = r0_en;
    in_instr   = instr;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b0;
    halt_sys     = 1'b0;
    mif.mem_ack  = 1'b0;
    mif.mem_rdata = 16'h0000;
    set_op(2'b00, 1'b0, 32'h0, 16'h0, 1'b0, 8'h00);

    // Reset state
    #3;
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_req", {31'd0, mif.mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_wb_data", {16'd0, wb_data}, 32'd0);
    #9 rst = 1'b1;

    // Non-memory op
    step();
    set_op(2'b00, 1'b1, 32'h0001_1234, 16'h0, 1'b1, 8'h4A);
    #1 chk("nm_stall", {31'd0, stall}, 32'd0);
    step();
    chk("nm_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("nm_wb_data", {16'd0, wb_data}, 32'h1234);
    chk("nm_wb_R0", {16'd0, wb_R0_data}, 32'h0001);
    chk("nm_wb_reg_wr", {31'd0, wb_reg_wr}, 32'd1);
    chk("nm_wb_R0_en", {31'd0, wb_R0_en}, 32'd1);
    chk("nm_wb_instr", {24'd0, wb_instr}, 32'h4A);
    chk("nm_stall2", {31'd0, stall}, 32'd0);

    // Load, ack in third WAIT cycle
    set_op(2'b01, 1'b1, 32'h0007_0040, 16'h0, 1'b0, 8'h21);
    #1 chk("ld_stall_idle", {31'd0, stall}, 32'd1);
    chk("ld_req_idle", {31'd0, mif.mem_req}, 32'd0);
    step();
    chk("ld_wb_valid_w1", {31'd0, wb_valid}, 32'd0);
    chk("ld_req_w1", {31'd0, mif.mem_req}, 32'd1);
    chk("ld_we", {31'd0, mif.mem_we}, 32'd0);
    chk("ld_addr_w1", {16'd0, mif.mem_addr}, 32'h0040);
    chk("ld_state_w1", {30'd0, dbg_state}, 32'd1);
    step();
    chk("ld_req_w2", {31'd0, mif.mem_req}, 32'd1);
    chk("ld_stall_w2", {31'd0, stall}, 32'd1);
    step();
    chk("ld_addr_w3", {16'd0, mif.mem_addr}, 32'h0040);
    chk("ld_stall_w3", {31'd0, stall}, 32'd1);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 16'hBEEF;
    step();
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 16'h0000;
    chk("ld_req_resp", {31'd0, mif.mem_req}, 32'd0);
    chk("ld_stall_resp", {31'd0, stall}, 32'd0);
    chk("ld_wb_valid_resp", {31'd0, wb_valid}, 32'd0);
    chk("ld_state_resp", {30'd0, dbg_state}, 32'd2);
    step();
    chk("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("ld_wb_data", {16'd0, wb_data}, 32'hBEEF);
    chk("ld_wb_reg_wr", {31'd0, wb_reg_wr}, 32'd1);
    chk("ld_wb_R0", {16'd0, wb_R0_data}, 32'h0007);
    chk("ld_wb_instr", {24'd0, wb_instr}, 32'h21);

    // Store, immediate ack
    set_op(2'b10, 1'b1, 32'h0000_0100, 16'h5A5A, 1'b0, 8'h33);
    #1 chk("st_stall_idle", {31'd0, stall}, 32'd1);
    step();
    chk("st_wb_valid_w", {31'd0, wb_valid}, 32'd0);
    chk("st_req", {31'd0, mif.mem_req}, 32'd1);
    chk("st_we", {31'd0, mif.mem_we}, 32'd1);
    chk("st_wdata", {16'd0, mif.mem_wdata}, 32'h5A5A);
    chk("st_addr", {16'd0, mif.mem_addr}, 32'h0100);
    mif.mem_ack = 1'b1;
    step();
    mif.mem_ack = 1'b0;
    chk("st_req_resp", {31'd0, mif.mem_req}, 32'd0);
    chk("st_stall_resp", {31'd0, stall}, 32'd0);
    step();
    chk("st_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("st_wb_reg_wr", {31'd0, wb_reg_wr}, 32'd0);
    chk("st_wb_data", {16'd0, wb_data}, 32'h0100);

    // Halt for 2 cycles mid-WAIT with a stray ack, then ack on the last counted cycle
    set_op(2'b01, 1'b1, 32'h0000_0080, 16'h0, 1'b0, 8'h12);
    step();
    chk("h_wb_valid_clr", {31'd0, wb_valid}, 32'd0);
    step();
    halt_sys      = 1'b1;
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 16'hDEAD;
    #1 chk("h_stall", {31'd0, stall}, 32'd1);
    step();
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 16'h0000;
    chk("h_req_hold1", {31'd0, mif.mem_req}, 32'd1);
    chk("h_state_hold1", {30'd0, dbg_state}, 32'd1);
    step();
    chk("h_req_hold2", {31'd0, mif.mem_req}, 32'd1);
    halt_sys = 1'b0;
    step();
    step();
    chk("h_req_post", {31'd0, mif.mem_req}, 32'd1);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 16'hCAFE;
    step();
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 16'h0000;
    chk("h_req_resp", {31'd0, mif.mem_req}, 32'd0);
    chk("h_err_none", {31'd0, mem_err}, 32'd0);
    step();
    chk("h_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("h_wb_data", {16'd0, wb_data}, 32'hCAFE);
    chk("h_wb_reg_wr", {31'd0, wb_reg_wr}, 32'd1);

    // Timeout: load with no ack
    set_op(2'b01, 1'b1, 32'h0009_0200, 16'h0, 1'b1, 8'h55);
    step();
    step();
    step();
    step();
    chk("to_req_w4", {31'd0, mif.mem_req}, 32'd1);
    chk("to_err_pre", {31'd0, mem_err}, 32'd0);
    step();
    chk("to_req_drop", {31'd0, mif.mem_req}, 32'd0);
    chk("to_err", {31'd0, mem_err}, 32'd1);
    step();
    chk("to_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("to_wb_reg_wr", {31'd0, wb_reg_wr}, 32'd0);
    chk("to_wb_R0_en", {31'd0, wb_R0_en}, 32'd0);
    set_op(2'b11, 1'b1, 32'h0000_7777, 16'h0, 1'b0, 8'h66);
    #1 chk("rsv_stall", {31'd0, stall}, 32'd0);
    step();
    chk("rsv_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("rsv_wb_data", {16'd0, wb_data}, 32'h7777);
    chk("to_err_sticky", {31'd0, mem_err}, 32'd1);

    // Reset during WAIT, then a normal load
    set_op(2'b01, 1'b1, 32'h0000_0300, 16'h0, 1'b0, 8'h77);
    step();
    chk("rw_req_pre", {31'd0, mif.mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rw_req", {31'd0, mif.mem_req}, 32'd0);
    chk("rw_stall", {31'd0, stall}, 32'd0);
    chk("rw_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rw_err", {31'd0, mem_err}, 32'd0);
    chk("rw_state", {30'd0, dbg_state}, 32'd0);
    step();
    #2 rst = 1'b1;
    set_op(2'b01, 1'b1, 32'h0000_0400, 16'h0, 1'b0, 8'h78);
    step();
    chk("rl_req", {31'd0, mif.mem_req}, 32'd1);
    chk("rl_addr", {16'd0, mif.mem_addr}, 32'h0400);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 16'h1357;
    step();
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 16'h0000;
    step();
    chk("rl_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("rl_wb_data", {16'd0, wb_data}, 32'h1357);
    chk("rl_wb_instr", {24'd0, wb_instr}, 32'h78);
    set_op(2'b00, 1'b0, 32'h0, 16'h0, 1'b0, 8'h00);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
